// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared FSM encoding, size derivations and saturation constants for the fixed-point unit
package fxp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_SQRT = 2'd2,
        ST_DONE = 2'd3
    } fxp_state_e;

    // Number of CHUNK-wide slices per operand.
    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // One root bit per iteration over the WIDTH+FBITS-bit scaled radicand.
    function automatic int calc_iter(input int width, input int fbits);
        return (width + fbits) / 2;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // Largest positive value for a width-bit signed word (truncate to width at the use site).
    function automatic logic [127:0] sat_max(input int width);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < width - 1; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Most negative value for a width-bit signed word (truncate to width at the use site).
    function automatic logic [127:0] sat_min(input int width);
        logic [127:0] m;
        m = '0;
        m[width-1] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/fxp_arith_unit_if.sv
// rtl/fxp_arith_unit_if.sv - request/response bundle between the issuing stage and the fixed-point unit
// master: drives start, operation, operand_1, operand_2; samples busy, done, result, overflow, invalid
// slave : the arithmetic unit itself
interface fxp_arith_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       operation;
    logic [WIDTH-1:0] operand_1;
    logic [WIDTH-1:0] operand_2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             invalid;

    modport master (
        output start, operation, operand_1, operand_2,
        input  busy, done, result, overflow, invalid
    );

    modport slave (
        input  start, operation, operand_1, operand_2,
        output busy, done, result, overflow, invalid
    );
endinterface

// File: rtl/fxp_chunk_mul.sv
// rtl/fxp_chunk_mul.sv - combinational CHUNK x CHUNK unsigned multiplier, time-shared by the MUL sequence
// Ports: a, b (CHUNK-bit unsigned slices) -> p (2*CHUNK-bit product)
module fxp_chunk_mul #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0]   a,
    input  logic [CHUNK-1:0]   b,
    output logic [2*CHUNK-1:0] p
);
    assign p = a * b;
endmodule

// File: rtl/fxp_arith_unit.sv
// rtl/fxp_arith_unit.sv - handshaked signed fixed-point add/sub/mul/sqrt unit
// Ports: clk, reset (async, active-high), bus (fxp_arith_unit_if.slave):
//   start/operation/operand_1/operand_2 in; busy/done/result/overflow/invalid out.
// Build option: FXP_SATURATE_EN clamps overflowed results to the signed range instead of wrapping.
`ifndef FPU_ADD
`define FPU_ADD  2'b00
`endif
`ifndef FPU_SUB
`define FPU_SUB  2'b01
`endif
`ifndef FPU_MUL
`define FPU_MUL  2'b10
`endif
`ifndef FPU_SQRT
`define FPU_SQRT 2'b11
`endif

module fxp_arith_unit
    import fxp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FBITS = 10,
    parameter int CHUNK = 16
) (
    input  logic            clk,
    input  logic            reset,
    fxp_arith_unit_if.slave bus
);
    localparam int NCH  = calc_nch(WIDTH, CHUNK);
    localparam int ITER = calc_iter(WIDTH, FBITS);
    localparam int ACCW = 2 * WIDTH;
    localparam int RADW = WIDTH + FBITS;
    localparam int REMW = ITER + 2;
    localparam int IDXW = idx_width(NCH);
    localparam int CNTW = idx_width(ITER);
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`ifdef FXP_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    fxp_state_e state_q, state_d;

    logic [WIDTH-1:0] mag_a_q, mag_b_q;
    logic             neg_q;
    logic [IDXW-1:0]  mi_q, mj_q;
    logic [ACCW-1:0]  acc_q;
    logic [RADW-1:0]  rad_q;
    logic [REMW-1:0]  rem_q;
    logic [ITER-1:0]  root_q;
    logic [CNTW-1:0]  it_q;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q, invalid_q;

    // ---------------- ADD / SUB, evaluated on the live inputs at accept ----------------
    logic [WIDTH-1:0] opa, opb, sum, diff, add_res, sub_res;
    logic             add_ovf, sub_ovf;

    assign opa  = bus.operand_1;
    assign opb  = bus.operand_2;
    assign sum  = opa + opb;
    assign diff = opa - opb;
    assign add_ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1]  != opa[WIDTH-1]);
    assign sub_ovf = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
    // On overflow the true sign always matches operand_1.
    assign add_res = (add_ovf && SATURATE) ? (opa[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum;
    assign sub_res = (sub_ovf && SATURATE) ? (opa[WIDTH-1] ? SAT_MIN : SAT_MAX) : diff;

    // ---------------- MUL: sign-magnitude, one partial product per cycle ----------------
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [CHUNK-1:0]   chunk_a, chunk_b;
    logic [2*CHUNK-1:0] pp;
    logic [ACCW-1:0]    acc_next;
    logic [WIDTH-1:0]   mag_field, mul_signed, mul_res;
    logic               mul_min_exact, mul_ovf, mul_last;

    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
    assign abs_a = opa[WIDTH-1] ? -opa : opa;
    assign abs_b = opb[WIDTH-1] ? -opb : opb;

    assign chunk_a = mag_a_q[int'(mi_q)*CHUNK +: CHUNK];
    assign chunk_b = mag_b_q[int'(mj_q)*CHUNK +: CHUNK];

    fxp_chunk_mul #(.CHUNK(CHUNK)) u_chunk_mul (
        .a (chunk_a),
        .b (chunk_b),
        .p (pp)
    );

    assign acc_next  = acc_q + (ACCW'(pp) << (CHUNK * (int'(mi_q) + int'(mj_q))));
    assign mag_field = acc_next[RADW-1:FBITS];
    // A truncated magnitude of exactly 2^(WIDTH-1) still fits when the result is negative.
    assign mul_min_exact = neg_q && (acc_next[ACCW-1:RADW] == '0) && (mag_field == SAT_MIN);
    assign mul_ovf    = (|acc_next[ACCW-1:RADW-1]) && !mul_min_exact;
    assign mul_signed = neg_q ? -mag_field : mag_field;
    assign mul_res    = (mul_ovf && SATURATE) ? (neg_q ? SAT_MIN : SAT_MAX) : mul_signed;
    assign mul_last   = (mi_q == IDXW'(NCH - 1)) && (mj_q == IDXW'(NCH - 1));

    // ---------------- SQRT: restoring recurrence, two radicand bits per step ----------------
    logic [REMW-1:0] rem_sh, trial, rem_nx;
    logic [ITER-1:0] root_nx;
    logic            sqrt_ge, sqrt_last;

    // rem_q stays below 2^ITER, so its two top bits are always zero and may be shifted out.
    assign rem_sh    = REMW'({rem_q, rad_q[RADW-1 -: 2]});
    assign trial     = {root_q, 2'b01};
    assign sqrt_ge   = (rem_sh >= trial);
    assign rem_nx    = sqrt_ge ? (rem_sh - trial) : rem_sh;
    assign root_nx   = {root_q[ITER-2:0], sqrt_ge};
    assign sqrt_last = (it_q == CNTW'(ITER - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.operation)
                        `FPU_MUL:  state_d = ST_MUL;
                        `FPU_SQRT: state_d = opa[WIDTH-1] ? ST_DONE : ST_SQRT;
                        default:   state_d = ST_DONE;
                    endcase
                end
            end
            ST_MUL:  if (mul_last)  state_d = ST_DONE;
            ST_SQRT: if (sqrt_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q != ST_IDLE);
        bus.done     = (state_q == ST_DONE);
        bus.result   = result_q;
        bus.overflow = overflow_q;
        bus.invalid  = invalid_q;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            neg_q      <= 1'b0;
            mi_q       <= '0;
            mj_q       <= '0;
            acc_q      <= '0;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            it_q       <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.operation)
                            `FPU_ADD: begin
                                result_q   <= add_res;
                                overflow_q <= add_ovf;
                                invalid_q  <= 1'b0;
                            end
                            `FPU_SUB: begin
                                result_q   <= sub_res;
                                overflow_q <= sub_ovf;
                                invalid_q  <= 1'b0;
                            end
                            `FPU_MUL: begin
                                mag_a_q <= abs_a;
                                mag_b_q <= abs_b;
                                neg_q   <= opa[WIDTH-1] ^ opb[WIDTH-1];
                                acc_q   <= '0;
                                mi_q    <= '0;
                                mj_q    <= '0;
                            end
                            default: begin
                                if (opa[WIDTH-1]) begin
                                    result_q   <= '0;
                                    overflow_q <= 1'b0;
                                    invalid_q  <= 1'b1;
                                end else begin
                                    rad_q  <= {opa, {FBITS{1'b0}}};
                                    rem_q  <= '0;
                                    root_q <= '0;
                                    it_q   <= '0;
                                end
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    acc_q <= acc_next;
                    if (mj_q == IDXW'(NCH - 1)) begin
                        mj_q <= '0;
                        mi_q <= mi_q + IDXW'(1);
                    end else begin
                        mj_q <= mj_q + IDXW'(1);
                    end
                    if (mul_last) begin
                        result_q   <= mul_res;
                        overflow_q <= mul_ovf;
                        invalid_q  <= 1'b0;
                    end
                end
                ST_SQRT: begin
                    rem_q  <= rem_nx;
                    root_q <= root_nx;
                    rad_q  <= rad_q << 2;
                    it_q   <= it_q + CNTW'(1);
                    if (sqrt_last) begin
                        result_q   <= WIDTH'(root_nx);
                        overflow_q <= 1'b0;
                        invalid_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
